// File: rtl/fifo_word_reader_if.sv
// FIFO read port plus packed-word output stream of the LZ4 input word reader.
// The reader owns the master view; the FIFO/consumer side uses the slave view.
interface fifo_word_reader_if #(
  parameter int DATA_W = 8,
  parameter int PACK_N = 4
);
  // FIFO read side
  logic                     fifo_rd_en;
  logic [DATA_W-1:0]        fifo_data_out;
  logic                     fifo_empty;
  // packed word stream
  logic [DATA_W*PACK_N-1:0] m_data;
  logic [PACK_N-1:0]        m_keep;
  logic                     m_last;
  logic                     m_valid;
  logic                     m_ready;

  modport master (
    output fifo_rd_en,
    input  fifo_data_out,
    input  fifo_empty,
    output m_data,
    output m_keep,
    output m_last,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_data_out,
    output fifo_empty,
    input  m_data,
    input  m_keep,
    input  m_last,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/fifo_word_reader.sv
// Byte-FIFO read master: issues rd_en, absorbs the 1-cycle read latency and
// packs PACK_N bytes little-endian into one word on a valid/ready stream.
// A flush drains outstanding reads and emits any partial word with keep/last.

// One assembly lane: holds a captured byte, cleared when the word leaves.
module fifo_word_reader_lane #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              clr_i,
  input  logic              cap_i,
  input  logic [DATA_W-1:0] byte_i,
  output logic [DATA_W-1:0] lane_o
);
  logic [DATA_W-1:0] lane_q;

  // clear wins over capture: a byte captured while the word loads goes out
  // through the bypass path instead of the lane register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)   lane_q <= '0;
    else if (clr_i) lane_q <= '0;
    else if (cap_i) lane_q <= byte_i;
  end

  assign lane_o = lane_q;
endmodule

module fifo_word_reader #(
  parameter int DATA_W = 8,
  parameter int PACK_N = 4,
  parameter int CNT_W  = 3
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic                flush,
  output logic                flush_done,
  fifo_word_reader_if.master  bus
);
  typedef enum logic [1:0] {FILL, DRAIN, EMIT, DONE} state_e;

  localparam logic [CNT_W-1:0] PACK_C = CNT_W'(PACK_N);
  localparam logic [CNT_W-1:0] ZERO_C = '0;

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d, sum;
  logic                          rd_pending_q;
  logic                          rd_en, out_free, word_full, load_full, emit_go, lane_clr;
  logic [PACK_N-1:0][DATA_W-1:0] lane_q, asm_w;
  logic [PACK_N-1:0]             lane_cap, keep_part;

  logic [DATA_W*PACK_N-1:0]      m_data_q, m_data_d;
  logic [PACK_N-1:0]             m_keep_q, m_keep_d;
  logic                          m_last_q, m_last_d;
  logic                          m_valid_q, m_valid_d;

  assign out_free = !m_valid_q || bus.m_ready;

  // bytes owned by the assembly once the in-flight read lands
  assign sum = cnt_q + CNT_W'(rd_pending_q);

  // a new read is allowed only if its byte has a lane to land in: either the
  // assembly has room, or the in-flight byte completes a word that leaves now
  assign rd_en = n_reset && (state_q == FILL) && !bus.fifo_empty && !flush &&
                 ((sum < PACK_C) || ((sum == PACK_C) && rd_pending_q && out_free));
  assign bus.fifo_rd_en = rd_en;

  // full either by the byte captured this cycle or held from earlier backpressure
  assign word_full = (cnt_q == PACK_C) || (rd_pending_q && (sum == PACK_C));
  assign load_full = word_full && out_free;
  assign emit_go   = (state_q == EMIT) && out_free;
  assign lane_clr  = load_full || emit_go;

  for (genvar g = 0; g < PACK_N; g++) begin : g_lane
    assign lane_cap[g]  = rd_pending_q && (cnt_q == CNT_W'(g));
    assign asm_w[g]     = lane_cap[g] ? bus.fifo_data_out : lane_q[g];
    assign keep_part[g] = (CNT_W'(g) < cnt_q);

    fifo_word_reader_lane #(.DATA_W(DATA_W)) u_lane (
      .clk     (clk),
      .n_reset (n_reset),
      .clr_i   (lane_clr),
      .cap_i   (lane_cap[g]),
      .byte_i  (bus.fifo_data_out),
      .lane_o  (lane_q[g])
    );
  end

  // read latency tracker: the FIFO presents data one cycle after rd_en
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) rd_pending_q <= 1'b0;
    else          rd_pending_q <= rd_en;
  end

  // lane counter: restarts whenever a word leaves the assembly
  always_comb begin
    cnt_d = cnt_q;
    if (lane_clr)          cnt_d = ZERO_C;
    else if (rd_pending_q) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) cnt_q <= ZERO_C;
    else          cnt_q <= cnt_d;
  end

  // output register next state: full words bypass the captured byte in,
  // flush words carry only the valid lanes
  always_comb begin
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
    m_valid_d = m_valid_q;
    if (m_valid_q && bus.m_ready) m_valid_d = 1'b0;
    if (load_full) begin
      m_data_d  = asm_w;
      m_keep_d  = '1;
      m_last_d  = 1'b0;
      m_valid_d = 1'b1;
    end else if (emit_go) begin
      m_data_d  = lane_q;
      m_keep_d  = keep_part;
      m_last_d  = 1'b1;
      m_valid_d = 1'b1;
    end
  end

  // output register: held while the consumer stalls
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign bus.m_data  = m_data_q;
  assign bus.m_keep  = m_keep_q;
  assign bus.m_last  = m_last_q;
  assign bus.m_valid = m_valid_q;

  // flush sequencing: drain the in-flight byte, let a full word leave through
  // the normal path, then emit whatever partial word remains
  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    case (state_q)
      FILL:  if (flush) state_d = DRAIN;
      DRAIN: if (!rd_pending_q && (cnt_q != PACK_C))
               state_d = (cnt_q == ZERO_C) ? DONE : EMIT;
      EMIT:  if (out_free) state_d = DONE;
      DONE: begin
        flush_done = 1'b1;
        state_d    = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state_q <= FILL;
    else          state_q <= state_d;
  end
endmodule
